// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory read port, decode-side queue
// head, redirect request and the delivered-instruction counter.
interface ifu_fetch_if;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        id_ready_i;
  logic        iram_rd_o;
  logic [31:0] pc_n_o;
  logic [31:0] inst_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [31:0] fetch_cnt_o;

  // The fetch unit itself.
  modport master (
    input  jump_i, jump_addr_i, id_ready_i, inst_i,
    output iram_rd_o, pc_n_o, inst_valid_o, inst_o, inst_pc_o, fetch_cnt_o
  );

  // The environment: decode stage plus instruction memory.
  modport slave (
    output jump_i, jump_addr_i, id_ready_i, inst_i,
    input  iram_rd_o, pc_n_o, inst_valid_o, inst_o, inst_pc_o, fetch_cnt_o
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues sequential reads to a 1-cycle-latency
// instruction memory, buffers responses in a small queue for decode and
// handles single-cycle redirects that flush everything in flight.
module ifu_fetch #(
  parameter logic [31:0] RST_PC = 32'h0800_0000,
  parameter int          QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master bus
);
  localparam int             PW       = (QDEPTH > 2) ? 2 : 1;
  localparam logic [3:0]     QDEPTH_W = 4'(QDEPTH);
  localparam logic [PW-1:0]  PTR_LAST = PW'(QDEPTH - 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [2:0]    count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          discard_q, discard_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   fetch_cnt_q, fetch_cnt_d;
  logic [31:0]   inst_mem_q [QDEPTH];
  logic [31:0]   pc_mem_q [QDEPTH];

  logic          pop_s;
  logic          push_s;
  logic          issue_s;
  logic [3:0]    occ_s;
  logic [31:0]   target_s;
  logic          unused_addr_s;

  // Queue pointer advance with explicit wrap at the last slot.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : (p + PW'(1));
  endfunction

  assign unused_addr_s = ^bus.jump_addr_i[1:0];
  assign target_s      = {bus.jump_addr_i[31:2], 2'b00};

  // Handshake decode: a read may issue only if its response is certain to
  // find a free slot once the current head pop is accounted for.
  always_comb begin
    pop_s   = (count_q != 3'd0) & bus.id_ready_i;
    occ_s   = {1'b0, count_q} + {3'b000, inflight_q} - {3'b000, pop_s};
    issue_s = ~bus.jump_i & (occ_s < QDEPTH_W);
    push_s  = inflight_q & ~discard_q & ~bus.jump_i;
  end

  // Memory read port; a redirect bypasses the queue check in its own cycle.
  always_comb begin
    if (rst) begin
      bus.iram_rd_o = 1'b0;
      bus.pc_n_o    = RST_PC;
    end else if (bus.jump_i) begin
      bus.iram_rd_o = 1'b1;
      bus.pc_n_o    = target_s;
    end else begin
      bus.iram_rd_o = issue_s;
      bus.pc_n_o    = fetch_pc_q;
    end
  end

  // Next-state: a redirect flushes the queue and makes the target read the
  // only one in flight; otherwise push/pop/issue update independently.
  always_comb begin
    fetch_cnt_d = pop_s ? (fetch_cnt_q + 32'd1) : fetch_cnt_q;
    if (bus.jump_i) begin
      count_d       = 3'd0;
      head_d        = {PW{1'b0}};
      tail_d        = {PW{1'b0}};
      fetch_pc_d    = target_s + 32'd4;
      inflight_pc_d = target_s;
      inflight_d    = 1'b1;
      discard_d     = 1'b0;
    end else begin
      count_d   = count_q + {2'b00, push_s} - {2'b00, pop_s};
      head_d    = pop_s ? next_ptr(head_q) : head_q;
      tail_d    = push_s ? next_ptr(tail_q) : tail_q;
      discard_d = discard_q;
      if (issue_s) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end else begin
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        fetch_pc_d    = fetch_pc_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RST_PC;
      count_q       <= 3'd0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      discard_q     <= 1'b0;
      head_q        <= {PW{1'b0}};
      tail_q        <= {PW{1'b0}};
      fetch_cnt_q   <= 32'd0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      discard_q     <= discard_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

  // Queue storage: responses land at the tail tagged with their address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        inst_mem_q[i] <= 32'd0;
        pc_mem_q[i]   <= 32'd0;
      end
    end else if (push_s) begin
      inst_mem_q[tail_q] <= bus.inst_i;
      pc_mem_q[tail_q]   <= inflight_pc_q;
    end else begin
      inst_mem_q[tail_q] <= inst_mem_q[tail_q];
      pc_mem_q[tail_q]   <= pc_mem_q[tail_q];
    end
  end

  assign bus.inst_valid_o = (count_q != 3'd0);
  assign bus.inst_o       = inst_mem_q[head_q];
  assign bus.inst_pc_o    = pc_mem_q[head_q];
  assign bus.fetch_cnt_o  = fetch_cnt_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: directed cycle table, hand-written corner
// sequences and a randomized run against a stream-level reference model.

// Queue must never be written while full.
module ifu_fetch_chk #(
  parameter int QDEPTH = 2
) (
  input logic       clk,
  input logic       rst,
  input logic       push_i,
  input logic [2:0] count_i
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push_i |-> (count_i < 3'(QDEPTH)));
endmodule

module tb_ifu_fetch;
  localparam logic [31:0] RST_PC = 32'h0800_0000;
  localparam int          QD     = 2;

  logic clk;
  logic rst;
  ifu_fetch_if bus();

  int errors = 0;
  int checks = 0;

  ifu_fetch #(.RST_PC(RST_PC), .QDEPTH(QD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ifu_fetch_chk #(.QDEPTH(QD)) u_chk (
    .clk(clk),
    .rst(rst),
    .push_i(dut.push_s),
    .count_i(dut.count_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // One-cycle-latency instruction memory.
  always @(posedge clk)
    bus.inst_i <= bus.iram_rd_o ? mem_f(bus.pc_n_o) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        jump;
    logic [31:0] addr;
    logic        ready;
    logic        exp_rd;
    logic [31:0] exp_pcn;
    logic        exp_valid;
    logic [31:0] exp_head;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mkv(input logic j, input logic [31:0] a, input logic r,
                               input logic rd, input logic [31:0] pcn,
                               input logic v, input logic [31:0] hd, input logic [31:0] c);
    vec_t t;
    t.jump = j; t.addr = a; t.ready = r; t.exp_rd = rd; t.exp_pcn = pcn;
    t.exp_valid = v; t.exp_head = hd; t.exp_cnt = c;
    return t;
  endfunction

  // Leaves the bench just after the negedge that releases reset (cycle 0).
  task automatic do_reset();
    bus.jump_i = 1'b0; bus.jump_addr_i = 32'd0; bus.id_ready_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] exp_pc;
  logic [31:0] m_cnt;
  logic [31:0] tgt;
  int          since;
  int          rd_seen;

  initial begin
    vecs[0]  = mkv(1'b0, 32'h0, 1'b1, 1'b1, 32'h0800_0000, 1'b0, 32'h0, 32'd0);
    vecs[1]  = mkv(1'b0, 32'h0, 1'b1, 1'b1, 32'h0800_0004, 1'b0, 32'h0, 32'd0);
    vecs[2]  = mkv(1'b0, 32'h0, 1'b1, 1'b1, 32'h0800_0008, 1'b1, 32'h0800_0000, 32'd0);
    vecs[3]  = mkv(1'b0, 32'h0, 1'b1, 1'b1, 32'h0800_000C, 1'b1, 32'h0800_0004, 32'd1);
    vecs[4]  = mkv(1'b0, 32'h0, 1'b1, 1'b1, 32'h0800_0010, 1'b1, 32'h0800_0008, 32'd2);
    vecs[5]  = mkv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0800_0014, 1'b1, 32'h0800_000C, 32'd3);
    vecs[6]  = mkv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0800_0014, 1'b1, 32'h0800_000C, 32'd3);
    vecs[7]  = mkv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0800_0014, 1'b1, 32'h0800_000C, 32'd3);
    vecs[8]  = mkv(1'b0, 32'h0, 1'b1, 1'b1, 32'h0800_0014, 1'b1, 32'h0800_000C, 32'd3);
    vecs[9]  = mkv(1'b1, 32'h0000_0102, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0800_0010, 32'd4);
    vecs[10] = mkv(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0104, 1'b0, 32'h0, 32'd4);
    vecs[11] = mkv(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100, 32'd4);
    vecs[12] = mkv(1'b1, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0104, 32'd5);
    vecs[13] = mkv(1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0, 32'd6);
    vecs[14] = mkv(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0204, 1'b0, 32'h0, 32'd6);
    vecs[15] = mkv(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0208, 1'b1, 32'h0000_0200, 32'd6);
    vecs[16] = mkv(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0204, 32'd7);
    vecs[17] = mkv(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'd8);
    vecs[18] = mkv(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC, 32'd8);
    vecs[19] = mkv(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'd9);
    vecs[20] = mkv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004, 32'd10);

    // Directed cycle table from reset release.
    do_reset();
    chk("reset_valid", {31'd0, bus.inst_valid_o}, 32'd0);
    chk("reset_cnt", bus.fetch_cnt_o, 32'd0);
    for (int i = 0; i < 21; i++) begin
      if (i > 0) @(negedge clk);
      bus.jump_i = vecs[i].jump;
      bus.jump_addr_i = vecs[i].addr;
      bus.id_ready_i = vecs[i].ready;
      #1;
      chk($sformatf("vec%0d_rd", i), {31'd0, bus.iram_rd_o}, {31'd0, vecs[i].exp_rd});
      chk($sformatf("vec%0d_pcn", i), bus.pc_n_o, vecs[i].exp_pcn);
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.inst_valid_o}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_cnt", i), bus.fetch_cnt_o, vecs[i].exp_cnt);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_head_pc", i), bus.inst_pc_o, vecs[i].exp_head);
        chk($sformatf("vec%0d_head_inst", i), bus.inst_o, mem_f(vecs[i].exp_head));
      end
    end

    // Asynchronous reset mid-stream, with a redirect request held high.
    @(negedge clk);
    bus.id_ready_i = 1'b1;
    bus.jump_i = 1'b1;
    bus.jump_addr_i = 32'h0000_4000;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rd", {31'd0, bus.iram_rd_o}, 32'd0);
    chk("async_rst_pcn", bus.pc_n_o, RST_PC);
    chk("async_rst_valid", {31'd0, bus.inst_valid_o}, 32'd0);
    chk("async_rst_inst", bus.inst_o, 32'd0);
    chk("async_rst_inst_pc", bus.inst_pc_o, 32'd0);
    chk("async_rst_cnt", bus.fetch_cnt_o, 32'd0);
    @(posedge clk); #1;
    chk("hold_rst_rd", {31'd0, bus.iram_rd_o}, 32'd0);
    chk("hold_rst_pcn", bus.pc_n_o, RST_PC);
    @(negedge clk);
    rst = 1'b0;
    bus.jump_i = 1'b0;
    #1;
    chk("release_rd", {31'd0, bus.iram_rd_o}, 32'd1);
    chk("release_pcn", bus.pc_n_o, RST_PC);

    // Decode stalled for 10 cycles, then released at full rate.
    do_reset();
    rd_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.iram_rd_o) rd_seen++;
    end
    chk("stall_reads", 32'(rd_seen), 32'(QD));
    chk("stall_rd_low", {31'd0, bus.iram_rd_o}, 32'd0);
    chk("stall_valid", {31'd0, bus.inst_valid_o}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.id_ready_i = 1'b1;
      #1;
      chk($sformatf("drain%0d_valid", k), {31'd0, bus.inst_valid_o}, 32'd1);
      chk($sformatf("drain%0d_pc", k), bus.inst_pc_o, RST_PC + 32'(4 * k));
    end

    // Randomized run against a stream model: between redirects/resets the
    // delivered PCs are strictly sequential, and the head is valid from the
    // second cycle after a redirect or reset release onward.
    do_reset();
    exp_pc = RST_PC;
    m_cnt = 32'd0;
    since = 0;
    for (int it = 0; it < 3000; it++) begin
      if (it > 0) @(negedge clk);
      if (it > 0 && $urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1;
        chk("rnd_rst_rd", {31'd0, bus.iram_rd_o}, 32'd0);
        chk("rnd_rst_pcn", bus.pc_n_o, RST_PC);
        chk("rnd_rst_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        chk("rnd_rst_cnt", bus.fetch_cnt_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = RST_PC;
        m_cnt = 32'd0;
        since = 0;
      end
      bus.id_ready_i = ($urandom_range(0, 2) != 0);
      bus.jump_i = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0: bus.jump_addr_i = $urandom;
        1: bus.jump_addr_i = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: bus.jump_addr_i = 32'h0000_1000 + 32'($urandom_range(0, 255));
      endcase
      #1;
      chk("rnd_cnt", bus.fetch_cnt_o, m_cnt);
      chk("rnd_valid", {31'd0, bus.inst_valid_o}, {31'd0, (since >= 2)});
      if (bus.jump_i) begin
        tgt = {bus.jump_addr_i[31:2], 2'b00};
        chk("rnd_jump_rd", {31'd0, bus.iram_rd_o}, 32'd1);
        chk("rnd_jump_pcn", bus.pc_n_o, tgt);
      end
      if (bus.inst_valid_o && bus.id_ready_i) begin
        chk("rnd_pop_pc", bus.inst_pc_o, exp_pc);
        chk("rnd_pop_inst", bus.inst_o, mem_f(exp_pc));
        exp_pc = exp_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
      end
      if (bus.jump_i) begin
        exp_pc = {bus.jump_addr_i[31:2], 2'b00};
        since = 1;
      end else if (since < 100) begin
        since++;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
